// File: rtl/riscv_decode_queue_pkg.sv
// Shared decode definitions: instruction formats, opcodes and the FIFO word.
// RISCV_M_EXT_EN adds the per-entry muldiv flag to decoded_instr_t.
package riscv_decode_queue_pkg;

  typedef enum logic [2:0] {
    NO_TYPE = 3'd0,
    R_TYPE  = 3'd1,
    I_TYPE  = 3'd2,
    S_TYPE  = 3'd3,
    B_TYPE  = 3'd4,
    U_TYPE  = 3'd5,
    J_TYPE  = 3'd6
  } instr_format_t;

  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_32    = 7'b0111011;

  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  // Immediate and PC are XLEN wide, so they live beside this word in the FIFO.
  typedef struct packed {
    logic          noop;
    logic          illegal;
    logic [6:0]    opcode;
    instr_format_t fmt;
    logic [2:0]    funct3;
    logic [6:0]    funct7;
    logic [4:0]    rs1;
    logic [4:0]    rs2;
    logic [4:0]    rd;
`ifdef RISCV_M_EXT_EN
    logic          muldiv;
`endif
  } decoded_instr_t;

  function automatic logic uses_rs1(input instr_format_t f);
    return (f == R_TYPE) || (f == I_TYPE) || (f == S_TYPE) || (f == B_TYPE);
  endfunction

  function automatic logic uses_rs2(input instr_format_t f);
    return (f == R_TYPE) || (f == S_TYPE) || (f == B_TYPE);
  endfunction

  function automatic logic uses_rd(input instr_format_t f);
    return (f == R_TYPE) || (f == I_TYPE) || (f == U_TYPE) || (f == J_TYPE);
  endfunction

endpackage

// File: rtl/riscv_decode_comb.sv
// Combinational RV32I/RV64I decoder: raw word -> decoded_instr_t plus XLEN immediate.
// RISCV_M_EXT_EN flags M-extension ops and, for XLEN=64, decodes OP-32 as R.
module riscv_decode_comb
  import riscv_decode_queue_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]      instr,
  input  logic             noop,
  output decoded_instr_t   dec,
  output logic [XLEN-1:0]  imm
);

  instr_format_t      fmt;
  logic signed [31:0] imm32;

  always_comb begin
    fmt = NO_TYPE;
    case (instr[6:0])
      OP:                                  fmt = R_TYPE;
      OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: fmt = I_TYPE;
      STORE:                               fmt = S_TYPE;
      BRANCH:                              fmt = B_TYPE;
      LUI, AUIPC:                          fmt = U_TYPE;
      JAL:                                 fmt = J_TYPE;
`ifdef RISCV_M_EXT_EN
      OP_32:                               fmt = (XLEN == 64) ? R_TYPE : NO_TYPE;
`endif
      default:                             fmt = NO_TYPE;
    endcase
  end

  // Every format fits a sign-extended 32-bit value; widen once at the end.
  always_comb begin
    imm32 = {{20{instr[31]}}, instr[31:20]};
    case (fmt)
      S_TYPE: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      B_TYPE: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      U_TYPE: imm32 = {instr[31:12], 12'h000};
      J_TYPE: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm32 = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

  assign imm = XLEN'(imm32);

  always_comb begin
    dec         = '0;
    dec.opcode  = instr[6:0];
    dec.fmt     = fmt;
    dec.funct3  = instr[14:12];
    dec.funct7  = instr[31:25];
    dec.rs1     = uses_rs1(fmt) ? instr[19:15] : 5'd0;
    dec.rs2     = uses_rs2(fmt) ? instr[24:20] : 5'd0;
    dec.rd      = uses_rd(fmt)  ? instr[11:7]  : 5'd0;
    dec.noop    = noop | (fmt == NO_TYPE);
    dec.illegal = ~noop & (fmt == NO_TYPE);
`ifdef RISCV_M_EXT_EN
    dec.muldiv  = (fmt == R_TYPE) && (instr[31:25] == FUNCT7_MULDIV);
`endif
  end

endmodule

// File: rtl/riscv_decode_queue.sv
// Decode stage with a DEPTH-entry valid/ready FIFO between fetch and execute.
// RISCV_M_EXT_EN adds the out_muldiv port.
module riscv_decode_queue
  import riscv_decode_queue_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             in_noop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_noop,
  output logic             out_illegal,
  output logic [6:0]       out_opcode,
  output instr_format_t    out_instr_format,
  output logic [2:0]       out_funct3,
  output logic [6:0]       out_funct7,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [4:0]       out_rd,
`ifdef RISCV_M_EXT_EN
  output logic             out_muldiv,
`endif
  output logic [XLEN-1:0]  out_imm,
  output logic [XLEN-1:0]  out_pc
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  decoded_instr_t  dec_in;
  logic [XLEN-1:0] imm_in;

  decoded_instr_t  mem     [DEPTH];
  logic [XLEN-1:0] imm_mem [DEPTH];
  logic [XLEN-1:0] pc_mem  [DEPTH];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, clr;

  riscv_decode_comb #(.XLEN(XLEN)) u_dec (
    .instr (in_instr),
    .noop  (in_noop),
    .dec   (dec_in),
    .imm   (imm_in)
  );

  assign in_ready  = (count != CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign clr       = ~rst_n | flush;

  // Reset and flush share one path; either one drops every queued entry.
  always_ff @(posedge clk) begin
    if (clr) begin
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem[wr_ptr]     <= dec_in;
      imm_mem[wr_ptr] <= imm_in;
      pc_mem[wr_ptr]  <= in_pc;
    end
  end

  // Payload is forced to zero while empty; a zero word decodes as NO_TYPE.
  decoded_instr_t  head;
  logic [XLEN-1:0] head_imm, head_pc;

  always_comb begin
    head     = '0;
    head_imm = '0;
    head_pc  = '0;
    if (out_valid) begin
      head     = mem[rd_ptr];
      head_imm = imm_mem[rd_ptr];
      head_pc  = pc_mem[rd_ptr];
    end
  end

  assign out_noop         = head.noop;
  assign out_illegal      = head.illegal;
  assign out_opcode       = head.opcode;
  assign out_instr_format = head.fmt;
  assign out_funct3       = head.funct3;
  assign out_funct7       = head.funct7;
  assign out_rs1          = head.rs1;
  assign out_rs2          = head.rs2;
  assign out_rd           = head.rd;
`ifdef RISCV_M_EXT_EN
  assign out_muldiv       = head.muldiv;
`endif
  assign out_imm          = head_imm;
  assign out_pc           = head_pc;

endmodule

// File: tb/tb_riscv_decode_queue.sv
// Bench for riscv_decode_queue: XLEN=32 and XLEN=64 instances share stimulus and are
// checked every cycle against a queue-based reference model plus literal expectations.
module tb_riscv_decode_queue;
  import riscv_decode_queue_pkg::*;

  localparam int DEPTH = 2;
`ifdef RISCV_M_EXT_EN
  localparam bit M_EN = 1'b1;
`else
  localparam bit M_EN = 1'b0;
`endif

  logic        clk, rst_n, flush, in_valid, in_noop, out_ready;
  logic [31:0] in_instr;
  logic [63:0] in_pc;

  logic          r32, v32, n32, il32, m32;
  logic [6:0]    op32, f7_32;
  logic [2:0]    f3_32;
  instr_format_t fm32;
  logic [4:0]    rs1_32, rs2_32, rd_32;
  logic [31:0]   imm32, pc32;

  logic          r64, v64, n64, il64, m64;
  logic [6:0]    op64, f7_64;
  logic [2:0]    f3_64;
  instr_format_t fm64;
  logic [4:0]    rs1_64, rs2_64, rd_64;
  logic [63:0]   imm64, pc64;

`ifndef RISCV_M_EXT_EN
  assign m32 = 1'b0;
  assign m64 = 1'b0;
`endif

  riscv_decode_queue #(.XLEN(32), .DEPTH(DEPTH)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r32),
    .in_instr(in_instr), .in_pc(in_pc[31:0]), .in_noop(in_noop), .out_valid(v32),
    .out_ready(out_ready), .out_noop(n32), .out_illegal(il32), .out_opcode(op32),
    .out_instr_format(fm32), .out_funct3(f3_32), .out_funct7(f7_32), .out_rs1(rs1_32),
    .out_rs2(rs2_32), .out_rd(rd_32),
`ifdef RISCV_M_EXT_EN
    .out_muldiv(m32),
`endif
    .out_imm(imm32), .out_pc(pc32));

  riscv_decode_queue #(.XLEN(64), .DEPTH(DEPTH)) dut64 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(r64),
    .in_instr(in_instr), .in_pc(in_pc), .in_noop(in_noop), .out_valid(v64),
    .out_ready(out_ready), .out_noop(n64), .out_illegal(il64), .out_opcode(op64),
    .out_instr_format(fm64), .out_funct3(f3_64), .out_funct7(f7_64), .out_rs1(rs1_64),
    .out_rs2(rs2_64), .out_rd(rd_64),
`ifdef RISCV_M_EXT_EN
    .out_muldiv(m64),
`endif
    .out_imm(imm64), .out_pc(pc64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    bit        valid, ready, noop, illegal;
    bit [6:0]  opcode;
    bit [2:0]  fmt;
    bit [2:0]  f3;
    bit [6:0]  f7;
    bit [4:0]  rs1, rs2, rd;
    bit        muldiv;
    bit [63:0] imm, pc;
  } obs_t;

  typedef struct {
    bit [31:0] instr;
    bit [63:0] pc;
    bit        noop;
  } ent_t;

  obs_t o32, o64;
  assign o32 = {v32, r32, n32, il32, op32, fm32, f3_32, f7_32, rs1_32, rs2_32, rd_32, m32,
                32'h0, imm32, 32'h0, pc32};
  assign o64 = {v64, r64, n64, il64, op64, fm64, f3_64, f7_64, rs1_64, rs2_64, rd_64, m64,
                imm64, pc64};

  int   n_chk = 0, n_pass = 0, cyc_no = 0;
  ent_t q[$];
  bit   m_acc, m_pop;

  // Reference: what the head must look like, derived straight from the ISA field rules.
  function automatic obs_t model(input ent_t e, input bit x64);
    obs_t      o;
    bit [6:0]  op;
    bit        r, i, s, b, u, j, legal;
    longint    v;
    o  = '0;
    op = e.instr[6:0];
    r  = (op == 7'h33) || (M_EN && x64 && op == 7'h3B);
    i  = op inside {7'h13, 7'h03, 7'h67, 7'h73, 7'h0F};
    s  = (op == 7'h23);
    b  = (op == 7'h63);
    u  = op inside {7'h37, 7'h17};
    j  = (op == 7'h6F);
    legal = r | i | s | b | u | j;
    o.valid   = 1'b1;
    o.opcode  = op;
    o.fmt     = r ? R_TYPE : i ? I_TYPE : s ? S_TYPE : b ? B_TYPE : u ? U_TYPE : j ? J_TYPE : NO_TYPE;
    o.f3      = e.instr[14:12];
    o.f7      = e.instr[31:25];
    o.rs1     = (r | i | s | b) ? e.instr[19:15] : 5'd0;
    o.rs2     = (r | s | b)     ? e.instr[24:20] : 5'd0;
    o.rd      = (r | i | u | j) ? e.instr[11:7]  : 5'd0;
    o.noop    = e.noop || !legal;
    o.illegal = !e.noop && !legal;
    o.muldiv  = M_EN && r && (e.instr[31:25] == 7'd1);
    if (s)      v = $signed({e.instr[31:25], e.instr[11:7]});
    else if (b) v = $signed({e.instr[31], e.instr[7], e.instr[30:25], e.instr[11:8], 1'b0});
    else if (u) v = $signed({e.instr[31:12], 12'h000});
    else if (j) v = $signed({e.instr[31], e.instr[19:12], e.instr[20], e.instr[30:21], 1'b0});
    else        v = $signed(e.instr[31:20]);
    o.imm = x64 ? 64'(v) : {32'h0, v[31:0]};
    o.pc  = x64 ? e.pc : {32'h0, e.pc[31:0]};
    return o;
  endfunction

  always @(posedge clk) begin
    if (!rst_n || flush) q.delete();
    else begin
      m_acc = in_valid && (q.size() < DEPTH);
      m_pop = (q.size() > 0) && out_ready;
      if (m_pop) void'(q.pop_front());
      if (m_acc) q.push_back('{in_instr, in_pc, in_noop});
    end
  end

  task automatic check_one(input string nm, input obs_t got, input bit x64);
    obs_t ex;
    if (q.size() == 0) begin
      ex = '0;
      ex.ready = 1'b1;
    end else begin
      ex = model(q[0], x64);
      ex.ready = (q.size() < DEPTH);
    end
    n_chk++;
    if (got === ex) n_pass++;
    else $display("FAIL %s cycle %0d: got %h expected %h", nm, cyc_no, got, ex);
  endtask

  task automatic lit(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  task automatic cyc();
    @(negedge clk);
    cyc_no++;
    check_one("model32", o32, 1'b0);
    check_one("model64", o64, 1'b1);
  endtask

  task automatic drive(input logic [31:0] ins, input logic [63:0] pc, input logic nop);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    in_noop  = nop;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [13] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h73, 7'h0F, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h3B, 7'h7F};
    logic [31:0] w;
    int          sel;
    w   = $urandom();
    sel = $urandom_range(0, 15);
    if ($urandom_range(0, 3) == 0) w[31:25] = 7'd1;
    if (sel < 13) w[6:0] = ops[sel];
    return w;
  endfunction

  initial begin
    ent_t pin;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0; in_noop = 1'b0;

    pin = '{32'hFFF10093, 64'h0, 1'b0};
    lit("pin_addi_imm", model(pin, 1'b1).imm, 64'hFFFF_FFFF_FFFF_FFFF);
    pin = '{32'hFF1FF0EF, 64'h0, 1'b0};
    lit("pin_jal_imm", model(pin, 1'b1).imm, 64'hFFFF_FFFF_FFFF_FFF0);
    pin = '{32'hFE20AC23, 64'h0, 1'b0};
    lit("pin_sw_imm", model(pin, 1'b0).imm, 64'h0000_0000_FFFF_FFF8);
    lit("pin_sw_rd", 64'(model(pin, 1'b0).rd), 64'd0);

    cyc();
    rst_n = 1'b1;
    lit("rst_in_ready", 64'(r32), 64'd1);
    lit("rst_out_valid", 64'(v32), 64'd0);
    lit("rst_imm", imm64, 64'd0);
    lit("rst_fmt", 64'(fm32), 64'(NO_TYPE));

    out_ready = 1'b1;
    drive(32'hFFF10093, 64'h100, 1'b0); cyc();
    lit("addi_valid", 64'(v32), 64'd1);
    lit("addi_fmt", 64'(fm32), 64'(I_TYPE));
    lit("addi_rs1", 64'(rs1_32), 64'd2);
    lit("addi_rd", 64'(rd_32), 64'd1);
    lit("addi_rs2", 64'(rs2_32), 64'd0);
    lit("addi_imm32", 64'(imm32), 64'hFFFF_FFFF);
    lit("addi_imm64", imm64, 64'hFFFF_FFFF_FFFF_FFFF);
    lit("addi_illegal", 64'(il32), 64'd0);
    drive(32'hFE000EE3, 64'h104, 1'b0); cyc();
    lit("beq_fmt", 64'(fm32), 64'(B_TYPE));
    lit("beq_rd", 64'(rd_32), 64'd0);
    lit("beq_imm", 64'(imm32), 64'hFFFF_FFFC);
    drive(32'h0000007F, 64'h108, 1'b0); cyc();
    lit("bad_noop", 64'(n32), 64'd1);
    lit("bad_illegal", 64'(il32), 64'd1);
    drive(32'h0000007F, 64'h10C, 1'b1); cyc();
    lit("bub_noop", 64'(n32), 64'd1);
    lit("bub_illegal", 64'(il32), 64'd0);
    drive(32'h800002B7, 64'h110, 1'b0); cyc();
    lit("lui_rd", 64'(rd_64), 64'd5);
    lit("lui_imm64", imm64, 64'hFFFF_FFFF_8000_0000);
    lit("lui_imm32", 64'(imm32), 64'h8000_0000);
`ifdef RISCV_M_EXT_EN
    drive(32'h022081B3, 64'h114, 1'b0); cyc();
    lit("mul_fmt", 64'(fm32), 64'(R_TYPE));
    lit("mul_regs", {49'd0, rs1_32, rs2_32, rd_32}, {49'd0, 5'd1, 5'd2, 5'd3});
    lit("mul_muldiv", 64'(m32), 64'd1);
    drive(32'h002081B3, 64'h118, 1'b0); cyc();
    lit("add_muldiv", 64'(m32), 64'd0);
`endif
    in_valid = 1'b0; cyc();
    lit("drain_valid", 64'(v32), 64'd0);

    // Back-pressure: third word waits, order preserved.
    out_ready = 1'b0;
    drive(32'h00000013, 64'h200, 1'b0); cyc();
    drive(32'h00100093, 64'h204, 1'b0); cyc();
    drive(32'h00200113, 64'h208, 1'b0);
    lit("full_ready", 64'(r32), 64'd0);
    cyc();
    lit("full_hold_pc", 64'(pc32), 64'h200);
    lit("full_hold_ready", 64'(r64), 64'd0);
    out_ready = 1'b1; cyc();
    lit("drain1_pc", 64'(pc32), 64'h204);
    cyc();
    lit("pushpop_pc", pc64, 64'h208);
    lit("pushpop_valid", 64'(v64), 64'd1);
    in_valid = 1'b0; cyc();
    lit("drain2_valid", 64'(v32), 64'd0);

    // Flush when full, then flush against an acceptable input; repeat with reset.
    for (int k = 0; k < 2; k++) begin
      out_ready = 1'b0;
      drive(32'h00000013, 64'h300, 1'b0); cyc();
      drive(32'h00000013, 64'h304, 1'b0); cyc();
      drive(32'h00000013, 64'h308, 1'b0);
      if (k == 0) flush = 1'b1; else rst_n = 1'b0;
      cyc();
      flush = 1'b0; rst_n = 1'b1;
      lit("clr_full_valid", 64'(v32), 64'd0);
      lit("clr_full_ready", 64'(r64), 64'd1);
      drive(32'h00000013, 64'h30C, 1'b0); cyc();
      drive(32'h00000013, 64'h310, 1'b0);
      if (k == 0) flush = 1'b1; else rst_n = 1'b0;
      cyc();
      flush = 1'b0; rst_n = 1'b1; in_valid = 1'b0;
      lit("clr_one_valid", 64'(v64), 64'd0);
      cyc();
      lit("clr_never_emit", 64'(v32), 64'd0);
    end

    for (int n = 0; n < 3000; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_pc     = {$urandom(), $urandom()};
      in_noop   = ($urandom_range(0, 7) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 39) == 0);
      rst_n     = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
